// File: rtl/gamepad_pkg.sv
// Shared definitions for the gamepad event path: button indices, event kinds,
// the 6-bit event record and the scheduler state encoding.
package gamepad_pkg;

  localparam int NUM_BTN = 12;

  localparam logic [3:0] BTN_R      = 4'd0;
  localparam logic [3:0] BTN_L      = 4'd1;
  localparam logic [3:0] BTN_X      = 4'd2;
  localparam logic [3:0] BTN_A      = 4'd3;
  localparam logic [3:0] BTN_RIGHT  = 4'd4;
  localparam logic [3:0] BTN_LEFT   = 4'd5;
  localparam logic [3:0] BTN_DOWN   = 4'd6;
  localparam logic [3:0] BTN_UP     = 4'd7;
  localparam logic [3:0] BTN_START  = 4'd8;
  localparam logic [3:0] BTN_SELECT = 4'd9;
  localparam logic [3:0] BTN_Y      = 4'd10;
  localparam logic [3:0] BTN_B      = 4'd11;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_REPEAT  = 2'd2
  } evt_kind_e;

  typedef struct packed {
    logic [3:0] button;
    evt_kind_e  kind;
  } evt_rec_t;

  localparam int EVT_W = $bits(evt_rec_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RPT  = 2'd2
  } sched_state_e;

  function automatic evt_rec_t mk_evt(input logic [3:0] button, input evt_kind_e kind);
    evt_rec_t r;
    r.button = button;
    r.kind   = kind;
    return r;
  endfunction

endpackage

// File: rtl/gamepad_evt_fifo.sv
// Show-ahead event queue; the head is registered so it holds its last value
// once the queue drains. Overflow is sticky until cleared.
module gamepad_evt_fifo
  import gamepad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [EVT_W-1:0] push_data,
  input  logic             pop,
  input  logic             clr_overflow,
  output logic [EVT_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [EVT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [EVT_W-1:0] head_q, head_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop, drop;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head     = head_q;
  assign overflow = ovf_q;

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // A write landing on the new read slot means the pushed entry is the new head.
    head_d = head_q;
    if (cnt_d != '0) begin
      head_d = (do_push && rd_d == wr_q) ? push_data : mem_q[rd_d];
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/gamepad_event_scheduler.sv
// Per-frame button scanner: debounces each button, emits PRESS/RELEASE events
// and auto-repeats the most recently pressed button into an event FIFO.
//
//   state   | meaning
//   IDLE    | waiting for frame_tick; snapshot taken on the tick
//   SCAN    | one button per cycle, idx 0..11, debounce and edge events
//   RPT     | one cycle: advance the repeat timer, maybe emit REPEAT
module gamepad_event_scheduler
  import gamepad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_RATE     = 6,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] buttons,
  input  logic        is_present,
  input  logic        frame_tick,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_button,
  output logic [1:0]  evt_kind,
  output logic [11:0] stable,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RPT_DELAY_L = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_RATE_L  = RW'(REPEAT_RATE);
  localparam logic [2:0]    DEB_L       = 3'(DEBOUNCE_FRAMES);

  sched_state_e     state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [11:0]      snap_q, snap_d;
  logic [11:0]      stable_q, stable_d;
  logic [11:0][1:0] cnt_q, cnt_d;
  logic [3:0]       held_idx_q, held_idx_d;
  logic             held_valid_q, held_valid_d;
  logic [RW-1:0]    rpt_cnt_q, rpt_cnt_d;
  logic [RW-1:0]    rpt_dec;
  logic             just_loaded_q, just_loaded_d;
  logic             push_q, push_d;
  evt_rec_t         push_rec_q, push_rec_d;
  logic [2:0]       cnt_inc;
  logic             cur_snap;

  logic [EVT_W-1:0] fifo_head;
  logic             fifo_empty;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    stable_d      = stable_q;
    cnt_d         = cnt_q;
    held_idx_d    = held_idx_q;
    held_valid_d  = held_valid_q;
    rpt_cnt_d     = rpt_cnt_q;
    just_loaded_d = just_loaded_q;
    push_d        = 1'b0;
    push_rec_d    = push_rec_q;
    cur_snap      = snap_q[idx_q];
    cnt_inc       = {1'b0, cnt_q[idx_q]} + 3'd1;
    rpt_dec       = rpt_cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_SCAN;
          idx_d   = 4'd0;
          snap_d  = is_present ? buttons : 12'h000;
        end
      end

      ST_SCAN: begin
        if (cur_snap == stable_q[idx_q]) begin
          cnt_d[idx_q] = 2'd0;
        end else if (cnt_inc == DEB_L) begin
          stable_d[idx_q] = cur_snap;
          cnt_d[idx_q]    = 2'd0;
          push_d          = 1'b1;
          if (cur_snap) begin
            push_rec_d    = mk_evt(idx_q, EVT_PRESS);
            held_idx_d    = idx_q;
            held_valid_d  = 1'b1;
            rpt_cnt_d     = RPT_DELAY_L;
            just_loaded_d = 1'b1;
          end else begin
            push_rec_d = mk_evt(idx_q, EVT_RELEASE);
            if (held_idx_q == idx_q) begin
              held_valid_d = 1'b0;
            end
          end
        end else begin
          cnt_d[idx_q] = cnt_inc[1:0];
        end

        if (idx_q == 4'd11) begin
          state_d = ST_RPT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      ST_RPT: begin
        // A press this frame only arms the timer; counting starts next frame.
        if (held_valid_q && !just_loaded_q) begin
          if (rpt_dec == '0) begin
            push_d     = 1'b1;
            push_rec_d = mk_evt(held_idx_q, EVT_REPEAT);
            rpt_cnt_d  = RPT_RATE_L;
          end else begin
            rpt_cnt_d = rpt_dec;
          end
        end
        just_loaded_d = 1'b0;
        state_d       = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      snap_q        <= '0;
      stable_q      <= '0;
      cnt_q         <= '0;
      held_idx_q    <= '0;
      held_valid_q  <= 1'b0;
      rpt_cnt_q     <= '0;
      just_loaded_q <= 1'b0;
      push_q        <= 1'b0;
      push_rec_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      stable_q      <= stable_d;
      cnt_q         <= cnt_d;
      held_idx_q    <= held_idx_d;
      held_valid_q  <= held_valid_d;
      rpt_cnt_q     <= rpt_cnt_d;
      just_loaded_q <= just_loaded_d;
      push_q        <= push_d;
      push_rec_q    <= push_rec_d;
    end
  end

  gamepad_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push_q),
    .push_data    (push_rec_q),
    .pop          (evt_ready),
    .clr_overflow (clr_overflow),
    .head         (fifo_head),
    .full         (),
    .empty        (fifo_empty),
    .overflow     (overflow)
  );

  assign evt_valid  = !fifo_empty;
  assign evt_button = fifo_head[5:2];
  assign evt_kind   = fifo_head[1:0];
  assign stable     = stable_q;

endmodule

// File: tb/tb_gamepad_event_scheduler.sv
// Directed plus randomized frame sequences checked against a frame-level
// reference model of debounce, auto-repeat and event timing.
module tb_gamepad_event_scheduler;
  import gamepad_pkg::*;

  localparam int DEB   = 2;
  localparam int DLY   = 20;
  localparam int RATE  = 6;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] buttons;
  logic        is_present;
  logic        frame_tick;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_button;
  logic [1:0]  evt_kind;
  logic [11:0] stable;
  logic        overflow;
  logic        clr_overflow;

  gamepad_event_scheduler #(
    .DEBOUNCE_FRAMES (DEB),
    .REPEAT_DELAY    (DLY),
    .REPEAT_RATE     (RATE),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .buttons      (buttons),
    .is_present   (is_present),
    .frame_tick   (frame_tick),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_button   (evt_button),
    .evt_kind     (evt_kind),
    .stable       (stable),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int btn;
    int kind;
    int cyc;
  } ev_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  reps_seen = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  // Reference model state, one entry per button plus a single repeat timer.
  bit [11:0] m_stable;
  int        m_cnt[12];
  int        m_held;
  bit        m_hv;
  int        m_rc;
  bit        m_jl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stable = '0;
    for (int i = 0; i < 12; i++) m_cnt[i] = 0;
    m_held = 0;
    m_hv   = 0;
    m_rc   = 0;
    m_jl   = 0;
  endtask

  // Events for one frame: edge events appear 2+k cycles after the tick, REPEAT at 14.
  task automatic model_frame(input bit [11:0] snap);
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (snap[i] == m_stable[i]) begin
        m_cnt[i] = 0;
      end else if (m_cnt[i] + 1 == DEB) begin
        m_stable[i] = snap[i];
        m_cnt[i] = 0;
        if (snap[i]) begin
          exp_q.push_back('{i, 0, 2 + i});
          m_held = i; m_hv = 1; m_rc = DLY; m_jl = 1;
        end else begin
          exp_q.push_back('{i, 1, 2 + i});
          if (m_held == i) m_hv = 0;
        end
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    if (m_hv && !m_jl) begin
      m_rc = m_rc - 1;
      if (m_rc == 0) begin
        exp_q.push_back('{m_held, 2, 14});
        m_rc = RATE;
      end
    end
    m_jl = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_frame(input bit [11:0] b, input bit p, input bit chk, input bit glitch);
    int n;
    buttons    = b;
    is_present = p;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    model_frame(p ? b : 12'h000);
    obs_q.delete();
    for (int j = 0; j < 18; j++) begin
      if (glitch && j == 5) begin
        frame_tick = 1'b1;
        buttons    = 12'($urandom);
        is_present = 1'b1;
      end else begin
        frame_tick = 1'b0;
      end
      if (evt_valid && evt_ready) begin
        obs_q.push_back('{int'(evt_button), int'(evt_kind), j});
        if (evt_kind == EVT_REPEAT) reps_seen++;
      end
      @(posedge clk); #1;
    end
    frame_tick = 1'b0;
    if (chk) begin
      check("evt_count", obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
        check("evt_button", obs_q[i].btn, exp_q[i].btn);
        check("evt_kind",   obs_q[i].kind, exp_q[i].kind);
        check("evt_cycle",  obs_q[i].cyc, exp_q[i].cyc);
      end
      check("stable", stable, m_stable);
      check("idle_empty", evt_valid, 0);
    end
  endtask

  initial begin
    bit [11:0] rb;
    reset        = 1'b1;
    buttons      = '0;
    is_present   = 1'b1;
    frame_tick   = 1'b0;
    evt_ready    = 1'b1;
    clr_overflow = 1'b0;
    do_reset();

    check("rst_evt_valid",  evt_valid, 0);
    check("rst_evt_button", evt_button, 0);
    check("rst_evt_kind",   evt_kind, 0);
    check("rst_stable",     stable, 0);
    check("rst_overflow",   overflow, 0);

    // a held for two frames: one PRESS(3)
    run_frame(12'h008, 1, 1, 0);
    check("a_first_none", obs_q.size(), 0);
    run_frame(12'h008, 1, 1, 0);
    check("a_press_n", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check("a_press_btn",  obs_q[0].btn, 3);
      check("a_press_kind", obs_q[0].kind, 0);
      check("a_press_lat",  obs_q[0].cyc, 5);
    end
    check("a_stable", stable, 12'h008);

    // one-frame glitch is filtered
    do_reset();
    run_frame(12'h008, 1, 1, 0);
    run_frame(12'h000, 1, 1, 0);
    check("glitch_none", obs_q.size(), 0);
    check("glitch_stable", stable, 0);

    // auto-repeat on up: press at frame 1, REPEAT at 21 and 27, release at 31
    do_reset();
    reps_seen = 0;
    for (int f = 0; f < 30; f++) run_frame(12'h080, 1, 1, 0);
    for (int f = 0; f < 12; f++) run_frame(12'h000, 1, 1, 0);
    check("repeat_total", reps_seen, 2);

    // overflow with stalled consumer
    do_reset();
    evt_ready = 1'b0;
    run_frame(12'hFFF, 1, 0, 0);
    run_frame(12'hFFF, 1, 0, 0);
    check("ovf_set", overflow, 1);
    check("ovf_valid", evt_valid, 1);
    check("ovf_stable", stable, 12'hFFF);
    evt_ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      check("ovf_head_valid", evt_valid, 1);
      check("ovf_head_btn", evt_button, j);
      check("ovf_head_kind", evt_kind, 0);
      @(posedge clk); #1;
    end
    check("ovf_drained", evt_valid, 0);
    check("hold_last_btn", evt_button, 3);
    check("hold_last_kind", evt_kind, 0);
    check("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);

    // pad disconnect releases stable buttons
    do_reset();
    run_frame(12'h030, 1, 1, 0);
    run_frame(12'h030, 1, 1, 0);
    check("pres_stable", stable, 12'h030);
    run_frame(12'h030, 0, 1, 0);
    run_frame(12'h030, 0, 1, 0);
    check("pres_rel_n", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("pres_rel0_btn", obs_q[0].btn, 4);
      check("pres_rel0_kind", obs_q[0].kind, 1);
      check("pres_rel1_btn", obs_q[1].btn, 5);
      check("pres_rel1_kind", obs_q[1].kind, 1);
    end

    // reset while idx 5 is being scanned, with release events in flight
    do_reset();
    run_frame(12'h0F0, 1, 1, 0);
    run_frame(12'h0F0, 1, 1, 0);
    run_frame(12'h000, 1, 1, 0);
    buttons    = 12'h000;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("abort_valid", evt_valid, 0);
    check("abort_stable", stable, 0);
    check("abort_ovf", overflow, 0);
    @(posedge clk); #1;
    check("abort_next_valid", evt_valid, 0);
    run_frame(12'h000, 1, 1, 0);
    run_frame(12'h100, 1, 1, 0);
    run_frame(12'h100, 1, 1, 0);

    // randomized frames, with occasional ticks during a scan that must be ignored
    rb = 12'($urandom);
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 9) < 4) rb = 12'($urandom);
      run_frame(rb, ($urandom_range(0, 7) != 0), 1, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
